// File: rtl/video_timing_gen.sv
// video_timing_gen
// Raster timing generator for the sprite pixel generator and HDMI/DVI encoder.
// Free-running horizontal/vertical counters cover the full blanked raster,
// with x=0 / y=0 at the start of sync. Every output is registered and decoded
// from the next-state counter values, so the strobes always describe the x/y
// presented in the same cycle. A PIPE-deep delay line provides copies of the
// sync/data-enable strobes that line up with the sprite-memory read latency.
//
// Ports:
//   i_clk        pixel clock
//   i_rst        asynchronous active-high reset
//   i_ce         count enable; low freezes every register
//   o_x, o_y     raw raster position (12 bits each)
//   o_vde        active video, aligned with o_x/o_y
//   o_hsync      horizontal sync (active level SYNC_POL), aligned with o_x/o_y
//   o_vsync      vertical sync (active level SYNC_POL), aligned with o_x/o_y
//   o_hsync_d, o_vsync_d, o_vde_d   strobes delayed by PIPE enabled cycles
//   o_sof        one-cycle start-of-frame pulse (qualify with i_ce)
//   o_frame_cnt  completed-frame counter, wraps at 65535
module video_timing_gen #(
  parameter int   WIDTH       = 1920,
  parameter int   HEIGHT      = 1080,
  parameter int   H_SYNC_TIME = 44,
  parameter int   H_F_PORCH   = 88,
  parameter int   H_B_PORCH   = 148,
  parameter int   V_SYNC_TIME = 5,
  parameter int   V_F_PORCH   = 4,
  parameter int   V_B_PORCH   = 36,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   PIPE        = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_vde,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hsync_d,
  output logic        o_vsync_d,
  output logic        o_vde_d,
  output logic        o_sof,
  output logic [15:0] o_frame_cnt
);

  localparam int H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH;
  localparam int V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH;

  // Inclusive bounds keep every constant inside 12 bits even when a total is 4096.
  localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_LAST = 12'(H_SYNC_TIME - 1);
  localparam logic [11:0] V_SYNC_LAST = 12'(V_SYNC_TIME - 1);
  localparam logic [11:0] H_ACT_FIRST = 12'(H_SYNC_TIME + H_B_PORCH);
  localparam logic [11:0] H_ACT_LAST  = 12'(H_SYNC_TIME + H_B_PORCH + WIDTH - 1);
  localparam logic [11:0] V_ACT_FIRST = 12'(V_SYNC_TIME + V_B_PORCH);
  localparam logic [11:0] V_ACT_LAST  = 12'(V_SYNC_TIME + V_B_PORCH + HEIGHT - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_errTotal
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  if (PIPE < 0 || PIPE > 7) begin : g_errPipe
    $error("video_timing_gen: PIPE must be in 0..7");
  end
  if (H_SYNC_TIME < 1 || V_SYNC_TIME < 1 || WIDTH < 1 || HEIGHT < 1) begin : g_errSize
    $error("video_timing_gen: sync widths and active sizes must be at least 1");
  end

  logic [11:0] r_x;
  logic [11:0] r_y;
  logic        r_vde;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_sof;
  logic [15:0] r_frameCnt;

  logic        w_xWrap;
  logic        w_sofNext;
  logic [11:0] w_xNext;
  logic [11:0] w_yNext;
  logic        w_hsyncNext;
  logic        w_vsyncNext;
  logic        w_vdeNext;

  // Next-state counters; the strobes are decoded from these so that they
  // land in the same cycle as the coordinates they describe.
  always_comb begin
    w_xWrap   = (r_x == H_LAST);
    w_sofNext = w_xWrap && (r_y == V_LAST);
    w_xNext   = w_xWrap ? 12'd0 : r_x + 12'd1;
    w_yNext   = r_y;
    if (w_xWrap) begin
      w_yNext = (r_y == V_LAST) ? 12'd0 : r_y + 12'd1;
    end
    w_hsyncNext = (w_xNext <= H_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    w_vsyncNext = (w_yNext <= V_SYNC_LAST) ? SYNC_POL : ~SYNC_POL;
    w_vdeNext   = (w_xNext >= H_ACT_FIRST) && (w_xNext <= H_ACT_LAST) &&
                  (w_yNext >= V_ACT_FIRST) && (w_yNext <= V_ACT_LAST);
  end

  // Counters and strobes; i_ce low holds everything, including a pending sof.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x        <= 12'd0;
      r_y        <= 12'd0;
      r_vde      <= 1'b0;
      r_hsync    <= SYNC_POL;
      r_vsync    <= SYNC_POL;
      r_sof      <= 1'b0;
      r_frameCnt <= 16'd0;
    end else if (i_ce) begin
      r_x     <= w_xNext;
      r_y     <= w_yNext;
      r_vde   <= w_vdeNext;
      r_hsync <= w_hsyncNext;
      r_vsync <= w_vsyncNext;
      r_sof   <= w_sofNext;
      if (w_sofNext) begin
        r_frameCnt <= r_frameCnt + 16'd1;
      end
    end
  end

  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_vde       = r_vde;
  assign o_hsync     = r_hsync;
  assign o_vsync     = r_vsync;
  assign o_sof       = r_sof;
  assign o_frame_cnt = r_frameCnt;

  // Delay line for {hsync, vsync, vde}; stage 0 captures the strobes currently
  // presented, so the last stage lags by exactly PIPE enabled cycles.
  if (PIPE == 0) begin : g_noPipe
    assign o_hsync_d = r_hsync;
    assign o_vsync_d = r_vsync;
    assign o_vde_d   = r_vde;
  end else begin : g_pipe
    logic [2:0] r_stage [PIPE];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < PIPE; i++) begin
          r_stage[i] <= 3'b000;
        end
      end else if (i_ce) begin
        r_stage[0] <= {r_hsync, r_vsync, r_vde};
        for (int i = 1; i < PIPE; i++) begin
          r_stage[i] <= r_stage[i-1];
        end
      end
    end

    assign {o_hsync_d, o_vsync_d, o_vde_d} = r_stage[PIPE-1];
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen.
// Three instances share clock, reset and enable:
//   uA  : default horizontal timing, short vertical raster (V 1/1/2/1, total 5)
//   uP0 : same as uA but PIPE=0 and SYNC_POL=0
//   uS  : small raster 14x7 (WIDTH=8, HEIGHT=4, H 2/2/2, V 1/1/1), PIPE=3
module tb_video_timing_gen;

   logic clock = 1'b0;
   logic reset;
   logic ce;

   logic [11:0] aX, aY, pX, pY, sX, sY;
   logic        aVde, aHsync, aVsync, aHsyncD, aVsyncD, aVdeD, aSof;
   logic        pVde, pHsync, pVsync, pHsyncD, pVsyncD, pVdeD, pSof;
   logic        sVde, sHsync, sVsync, sHsyncD, sVsyncD, sVdeD, sSof;
   logic [15:0] aFrameCnt, pFrameCnt, sFrameCnt;

   int checkCount = 0;
   int errorCount = 0;

   // Free-running pixel clock, 10 ns period.
   always #5 clock = ~clock;

   video_timing_gen #(
      .V_SYNC_TIME(1), .V_B_PORCH(1), .HEIGHT(2), .V_F_PORCH(1)
   ) uA (
      .i_clk(clock), .i_rst(reset), .i_ce(ce),
      .o_x(aX), .o_y(aY), .o_vde(aVde), .o_hsync(aHsync), .o_vsync(aVsync),
      .o_hsync_d(aHsyncD), .o_vsync_d(aVsyncD), .o_vde_d(aVdeD),
      .o_sof(aSof), .o_frame_cnt(aFrameCnt)
   );

   video_timing_gen #(
      .V_SYNC_TIME(1), .V_B_PORCH(1), .HEIGHT(2), .V_F_PORCH(1),
      .PIPE(0), .SYNC_POL(1'b0)
   ) uP0 (
      .i_clk(clock), .i_rst(reset), .i_ce(ce),
      .o_x(pX), .o_y(pY), .o_vde(pVde), .o_hsync(pHsync), .o_vsync(pVsync),
      .o_hsync_d(pHsyncD), .o_vsync_d(pVsyncD), .o_vde_d(pVdeD),
      .o_sof(pSof), .o_frame_cnt(pFrameCnt)
   );

   video_timing_gen #(
      .WIDTH(8), .HEIGHT(4), .H_SYNC_TIME(2), .H_F_PORCH(2), .H_B_PORCH(2),
      .V_SYNC_TIME(1), .V_F_PORCH(1), .V_B_PORCH(1), .PIPE(3)
   ) uS (
      .i_clk(clock), .i_rst(reset), .i_ce(ce),
      .o_x(sX), .o_y(sY), .o_vde(sVde), .o_hsync(sHsync), .o_vsync(sVsync),
      .o_hsync_d(sHsyncD), .o_vsync_d(sVsyncD), .o_vde_d(sVdeD),
      .o_sof(sSof), .o_frame_cnt(sFrameCnt)
   );

   // Drive reset and enable together, away from the clock edge.
   task automatic applyStimulus(input logic rstVal, input logic ceVal);
      reset = rstVal;
      ce    = ceVal;
   endtask

   // Advance one clock and settle 1 ns past the rising edge before sampling.
   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Stimulus and checking sequence.
   initial begin
      int  sFirstSof = -1, sSofCount = 0, sVdeCount = 0, sVsyncHigh = 0;
      int  sVsyncBadY = 0, sPipeErr = 0, sFrameAt98 = -1;
      int  aHsyncHigh = 0, aHsyncBadX = 0, aVdeCount = 0;
      int  aVdeFirstX = -1, aVdeFirstY = -1, aVdeLastX = -1;
      int  aPrevZero = -1, aPeriod = -1, pHsyncLow = 0, pPipeErr = 0;
      int  aVsyncAt2199 = -1, aVsyncAt2200 = -1, aYAt6600 = -1;
      bit  found;
      logic sVdeHist [0:98];
      logic expD;

      applyStimulus(1'b1, 1'b1);
      repeat (3) stepCycle();

      // Reset values with reset held.
      checkOutput("rst_x", 32'(aX), 32'd0);
      checkOutput("rst_y", 32'(aY), 32'd0);
      checkOutput("rst_hsync", 32'(aHsync), 32'd1);
      checkOutput("rst_vsync", 32'(aVsync), 32'd1);
      checkOutput("rst_vde_d", 32'(sVdeD), 32'd0);
      checkOutput("rst_pol0_hsync", 32'(pHsync), 32'd0);

      applyStimulus(1'b0, 1'b1);
      sVdeHist[0] = 1'b0;

      for (int n = 1; n <= 6600; n++) begin
         stepCycle();
         if (n <= 98) begin
            sVdeHist[n] = sVde;
            if (sSof) begin
               sSofCount++;
               if (sFirstSof < 0) sFirstSof = n;
            end
            if (sVde) sVdeCount++;
            if (sVsync) begin
               sVsyncHigh++;
               if (sY != 12'd0) sVsyncBadY++;
            end
            expD = (n >= 3) ? sVdeHist[n-3] : 1'b0;
            if (sVdeD !== expD) sPipeErr++;
            if (n == 98) sFrameAt98 = int'(sFrameCnt);
         end
         if (n <= 2200) begin
            if (aHsync) begin
               aHsyncHigh++;
               if (aX >= 12'd44) aHsyncBadX++;
            end
            if (!pHsync) pHsyncLow++;
         end
         if (aVde) begin
            aVdeCount++;
            if (aVdeFirstX < 0) begin
               aVdeFirstX = int'(aX);
               aVdeFirstY = int'(aY);
            end
            aVdeLastX = int'(aX);
         end
         if (aX == 12'd0) begin
            if (aPrevZero >= 0) aPeriod = n - aPrevZero;
            aPrevZero = n;
         end
         if (pVdeD !== pVde) pPipeErr++;
         if (n == 2199) aVsyncAt2199 = int'(aVsync);
         if (n == 2200) aVsyncAt2200 = int'(aVsync);
         if (n == 6600) aYAt6600 = int'(aY);
      end

      // Small-raster frame: wrap, sof, frame count, vsync and vde totals.
      checkOutput("s_first_sof_cycle", 32'(sFirstSof), 32'd98);
      checkOutput("s_sof_count_frame", 32'(sSofCount), 32'd1);
      checkOutput("s_frame_cnt_at_sof", 32'(sFrameAt98), 32'd1);
      checkOutput("s_vde_per_frame", 32'(sVdeCount), 32'd32);
      checkOutput("s_vsync_high_cycles", 32'(sVsyncHigh), 32'd14);
      checkOutput("s_vsync_outside_y0", 32'(sVsyncBadY), 32'd0);
      checkOutput("s_pipe3_vde_d_errors", 32'(sPipeErr), 32'd0);

      // Default horizontal timing.
      checkOutput("a_hsync_high_cycles", 32'(aHsyncHigh), 32'd44);
      checkOutput("a_hsync_high_bad_x", 32'(aHsyncBadX), 32'd0);
      checkOutput("a_vde_first_x", 32'(aVdeFirstX), 32'd192);
      checkOutput("a_vde_first_y", 32'(aVdeFirstY), 32'd2);
      checkOutput("a_vde_last_x", 32'(aVdeLastX), 32'd2111);
      checkOutput("a_vde_line_count", 32'(aVdeCount), 32'd1920);
      checkOutput("a_line_period", 32'(aPeriod), 32'd2200);
      checkOutput("a_vsync_end_of_line0", 32'(aVsyncAt2199), 32'd1);
      checkOutput("a_vsync_at_wrap", 32'(aVsyncAt2200), 32'd0);
      checkOutput("a_y_after_three_lines", 32'(aYAt6600), 32'd3);
      checkOutput("p_pol0_hsync_low_cycles", 32'(pHsyncLow), 32'd44);
      checkOutput("p_pipe0_vde_d_errors", 32'(pPipeErr), 32'd0);

      // ce gating: uA sits at x=0,y=3; advance to x=195 inside the active area.
      repeat (195) stepCycle();
      checkOutput("ce_pre_x", 32'(aX), 32'd195);
      checkOutput("ce_pre_vde", 32'(aVde), 32'd1);
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         stepCycle();
         checkOutput("ce_hold_x", 32'(aX), 32'd195);
         checkOutput("ce_hold_vde", 32'(aVde), 32'd1);
         checkOutput("ce_hold_hsync_d", 32'(aHsyncD), 32'd0);
      end
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      checkOutput("ce_resume_x0", 32'(aX), 32'd196);
      stepCycle();
      checkOutput("ce_resume_x1", 32'(aX), 32'd197);

      // Frame counter wrap on uS: preload 65535 just before the final clock.
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         if (sX == 12'd13 && sY == 12'd6) found = 1'b1;
         else stepCycle();
      end
      checkOutput("wrap_reached_last_pos", 32'(found), 32'd1);
      force uS.r_frameCnt = 16'hFFFF;
      #2;
      release uS.r_frameCnt;
      checkOutput("wrap_preload", 32'(sFrameCnt), 32'd65535);
      stepCycle();
      checkOutput("wrap_frame_cnt", 32'(sFrameCnt), 32'd0);
      checkOutput("wrap_sof", 32'(sSof), 32'd1);

      // Asynchronous reset mid-line at x=1000.
      found = 1'b0;
      for (int k = 0; k < 2300 && !found; k++) begin
         if (aX == 12'd1000) found = 1'b1;
         else stepCycle();
      end
      checkOutput("midline_reached_x1000", 32'(found), 32'd1);
      applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("async_rst_x", 32'(aX), 32'd0);
      checkOutput("async_rst_y", 32'(aY), 32'd0);
      checkOutput("async_rst_vde", 32'(aVde), 32'd0);
      checkOutput("async_rst_hsync", 32'(aHsync), 32'd1);
      checkOutput("async_rst_vsync", 32'(aVsync), 32'd1);
      checkOutput("async_rst_hsync_d", 32'(aHsyncD), 32'd0);
      checkOutput("async_rst_vde_d", 32'(aVdeD), 32'd0);
      checkOutput("async_rst_frame_cnt", 32'(sFrameCnt), 32'd0);
      checkOutput("async_rst_sof", 32'(sSof), 32'd0);
      stepCycle();
      applyStimulus(1'b0, 1'b1);
      stepCycle();
      checkOutput("post_rst_x", 32'(aX), 32'd1);
      checkOutput("post_rst_y", 32'(aY), 32'd0);
      checkOutput("post_rst_sof", 32'(aSof), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
